// File: rtl/agc_tone_gen.sv
// rtl/agc_tone_gen.sv - triangle/stepped-amplitude tone source for the AGC sample input
// Optional square-wave output enabled by AGC_TONE_SQUARE_EN (adds wave_sel input).
module agc_tone_gen #(
  parameter int SAMPLE_DIV    = 4,
  parameter int PERIOD_LOG2   = 5,
  parameter int DWELL_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_step,
  input  logic [6:0] amp_lo,
  input  logic [6:0] amp_hi,
`ifdef AGC_TONE_SQUARE_EN
  input  logic       wave_sel,
`endif
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic [6:0] amp_now,
  output logic       period_wrap,
  output logic       busy
);

  localparam int N     = PERIOD_LOG2;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int DW_W  = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [N-1:0]     phase;
  logic [DW_W-1:0]  dwell;
  logic [6:0]       amp_lo_r;
  logic [6:0]       amp_hi_r;
  logic             mode_r;
`ifdef AGC_TONE_SQUARE_EN
  logic             wave_r;
`endif

  logic [N-2:0]        fold;
  logic [7:0]          ramp_u;
  logic signed [7:0]   ramp_c;
  logic signed [7:0]   amp_s;
  logic signed [15:0]  prod;
  logic [7:0]          tri_sample;
  logic [7:0]          next_sample;

  // Fold the phase into a rising/falling ramp centred on zero, then scale by amp/64.
  always_comb begin
    fold       = phase[N-1] ? ~phase[N-2:0] : phase[N-2:0];
    ramp_u     = 8'(fold) << (8 - N);
    ramp_c     = signed'(ramp_u - 8'd64);
    amp_s      = signed'({1'b0, amp_now});
    prod       = 16'(ramp_c) * 16'(amp_s);
    tri_sample = 8'(prod >>> 6);
`ifdef AGC_TONE_SQUARE_EN
    if (wave_r)
      next_sample = phase[N-1] ? {1'b0, amp_now} : 8'd0 - {1'b0, amp_now};
    else
      next_sample = tri_sample;
`else
    next_sample = tri_sample;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      phase        <= '0;
      dwell        <= '0;
      amp_lo_r     <= '0;
      amp_hi_r     <= '0;
      mode_r       <= 1'b0;
`ifdef AGC_TONE_SQUARE_EN
      wave_r       <= 1'b0;
`endif
      sample_out   <= '0;
      sample_valid <= 1'b0;
      amp_now      <= '0;
      period_wrap  <= 1'b0;
      busy         <= 1'b0;
    end else if (state != IDLE && stop) begin
      state        <= IDLE;
      div_cnt      <= '0;
      phase        <= '0;
      dwell        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      amp_now      <= '0;
      period_wrap  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sample_valid <= 1'b0;
          period_wrap  <= 1'b0;
          if (start && !stop) begin
            state    <= RUN_LO;
            amp_lo_r <= amp_lo;
            amp_hi_r <= amp_hi;
            mode_r   <= mode_step;
`ifdef AGC_TONE_SQUARE_EN
            wave_r   <= wave_sel;
`endif
            amp_now  <= amp_lo;
            div_cnt  <= '0;
            phase    <= '0;
            dwell    <= '0;
            busy     <= 1'b1;
          end
        end
        RUN_LO, RUN_HI: begin
          sample_valid <= 1'b0;
          period_wrap  <= 1'b0;
          if (div_cnt == DIV_MAX) begin
            div_cnt      <= '0;
            sample_out   <= next_sample;
            sample_valid <= 1'b1;
            phase        <= phase + 1'b1;
            if (&phase) begin
              period_wrap <= 1'b1;
              if (dwell == DWELL_MAX) begin
                // Without step mode the dwell count simply parks at its maximum.
                if (mode_r) begin
                  dwell <= '0;
                  if (state == RUN_LO) begin
                    state   <= RUN_HI;
                    amp_now <= amp_hi_r;
                  end else begin
                    state   <= RUN_LO;
                    amp_now <= amp_lo_r;
                  end
                end
              end else begin
                dwell <= dwell + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agc_tone_gen.sv
// tb/tb_agc_tone_gen.sv - scoreboard bench for agc_tone_gen against a sample-index reference model
module tb_agc_tone_gen;

  localparam int SDIV  = 4;
  localparam int NLOG  = 5;
  localparam int DWELL = 2;
  localparam int PER   = 1 << NLOG;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode_step;
  logic [6:0] amp_lo;
  logic [6:0] amp_hi;
  logic       wave_sel;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic [6:0] amp_now;
  logic       period_wrap;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] s;
    logic       w;
    logic [6:0] a;
    int         at;
  } exp_t;

  exp_t q[$];

  agc_tone_gen #(
    .SAMPLE_DIV   (SDIV),
    .PERIOD_LOG2  (NLOG),
    .DWELL_PERIODS(DWELL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode_step   (mode_step),
    .amp_lo      (amp_lo),
    .amp_hi      (amp_hi),
`ifdef AGC_TONE_SQUARE_EN
    .wave_sel    (wave_sel),
`endif
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .amp_now     (amp_now),
    .period_wrap (period_wrap),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int amp_at(int k, int lo, int hi, bit mode);
    int per;
    per = k / PER;
    if (mode && ((per / DWELL) % 2 == 1)) return hi;
    return lo;
  endfunction

  function automatic int samp_at(int k, int lo, int hi, bit mode, bit wave);
    int p, a, f, c, pr;
    p = k % PER;
    a = amp_at(k, lo, hi, mode);
    if (wave) return (p >= PER / 2) ? a : -a;
    f  = (p < PER / 2) ? p : PER - 1 - p;
    c  = f * (256 / PER) - 64;
    pr = c * a;
    if (pr >= 0) return pr / 64;
    return -((-pr + 63) / 64);
  endfunction

  // Monitor: every strobe must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (period_wrap && !sample_valid) chk("wrap_without_valid", 1, 0);
    if (sample_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_out", sample_out, e.s);
        chk("period_wrap", period_wrap, e.w);
        chk("amp_now", amp_now, e.a);
        chk("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic run(input int lo, input int hi, input bit mode, input bit wave,
                     input int n, input bit use_reset, input bit poke);
    int  a0, s;
    bit  w;
    exp_t e;
`ifdef AGC_TONE_SQUARE_EN
    w = wave;
`else
    w = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; amp_lo = 7'(lo); amp_hi = 7'(hi); mode_step = mode; wave_sel = wave;
    @(negedge clk);
    start = 1'b0;
    a0 = cyc;
    for (int k = 0; k < n; k++) begin
      s    = samp_at(k, lo, hi, mode, w);
      e.s  = s[7:0];
      e.w  = ((k % PER) == PER - 1);
      e.a  = 7'(amp_at(k + 1, lo, hi, mode));
      e.at = a0 + SDIV * (k + 1);
      q.push_back(e);
    end
    chk("busy_after_start", busy, 1);
    chk("amp_after_start", amp_now, lo);
    for (int i = 1; i <= SDIV * n + 1; i++) begin
      @(negedge clk);
      if (poke && i == 6) begin
        start = 1'b1; amp_lo = 7'($urandom_range(0, 127));
        amp_hi = 7'($urandom_range(0, 127)); mode_step = ~mode; wave_sel = ~wave;
      end
      if (poke && i == 7) start = 1'b0;
    end
    if (use_reset) begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    chk("busy_after_stop", busy, 0);
    chk("sample_after_stop", sample_out, 0);
    chk("amp_after_stop", amp_now, 0);
    chk("valid_after_stop", sample_valid, 0);
    repeat (2 * SDIV) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired actual timeout required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_step = 1'b0;
    amp_lo = '0; amp_hi = '0; wave_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sample", sample_out, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_amp", amp_now, 0);
    chk("reset_wrap", period_wrap, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;

    run(40, 0, 1'b0, 1'b0, 40, 1'b0, 1'b1);
    run(20, 100, 1'b1, 1'b0, 140, 1'b0, 1'b1);
    run(127, 5, 1'b0, 1'b0, 20, 1'b0, 1'b0);
    run(0, 90, 1'b0, 1'b0, 36, 1'b0, 1'b0);
    run(60, 10, 1'b1, 1'b0, 70, 1'b1, 1'b1);
`ifdef AGC_TONE_SQUARE_EN
    run(50, 0, 1'b0, 1'b1, 34, 1'b0, 1'b0);
`endif

    @(negedge clk);
    start = 1'b1; stop = 1'b1; amp_lo = 7'd33;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle_busy", busy, 0);
    repeat (3 * SDIV) @(negedge clk);
    chk("start_stop_idle_busy_late", busy, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 140);
      run($urandom_range(0, 127), $urandom_range(0, 127), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), n, 1'($urandom_range(0, 3) == 0), n >= 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
